// File: rtl/smc_access_sched.sv
// smc_access_sched: round-robin I/D address-window checker with cache-line encryption handshake
module smc_access_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_clr,
  input  logic [31:0] cfg_low,
  input  logic [31:0] cfg_high,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic        iack,
  output logic        ihit,
  input  logic        dreq,
  input  logic [31:0] daddr,
  output logic        dack,
  output logic        dhit,
  output logic        cl_req,
  output logic [31:0] cl_addr,
  output logic        cl_src,
  input  logic        cl_done,
  output logic        win_en,
  output logic [31:0] win_low,
  output logic [31:0] win_high,
  output logic        busy,
  output logic        err
);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, CHECK, CL_REQ, ACK} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, low_q, low_d, high_q, high_d, plow_q, plow_d, phigh_q, phigh_d, cfg_l, cfg_h;
  logic [7:0] cnt_q, cnt_d;
  logic src_q, src_d, hit_q, hit_d, prio_q, prio_d, en_q, en_d, err_q, err_d, pend_q, pend_d, pclr_q, pclr_d;
  logic live, cfg_v, cfg_c, cfg_ok, gsrc, win_hit, tmo;
  always_comb begin
    live = cfg_we | cfg_clr;
    cfg_v = live | pend_q;
    cfg_c = live ? cfg_clr : pclr_q;
    cfg_l = live ? cfg_low : plow_q;
    cfg_h = live ? cfg_high : phigh_q;
    cfg_ok = cfg_l <= cfg_h;
    gsrc = (ireq & dreq) ? prio_q : dreq;
    win_hit = en_q && (low_q <= addr_q) && (addr_q <= high_q);
    tmo = !cl_done && (cnt_q == TMAX);
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    src_d = src_q;
    hit_d = hit_q;
    prio_d = prio_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (ireq | dreq) begin
        state_d = CHECK;
        addr_d = gsrc ? daddr : iaddr;
        src_d = gsrc;
        prio_d = ~gsrc;
      end
      CHECK: begin
        state_d = win_hit ? CL_REQ : ACK;
        hit_d = win_hit;
        cnt_d = '0;
      end
      CL_REQ: begin
        state_d = (cl_done | tmo) ? ACK : CL_REQ;
        hit_d = cl_done;
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    en_d = en_q;
    low_d = low_q;
    high_d = high_q;
    err_d = err_q | (state_q == CL_REQ && tmo);
    pend_d = pend_q;
    pclr_d = pclr_q;
    plow_d = plow_q;
    phigh_d = phigh_q;
    if (state_q == IDLE) begin
      pend_d = 1'b0;
      if (cfg_v && cfg_c) en_d = 1'b0;
      else if (cfg_v) begin
        en_d = cfg_ok;
        err_d = !cfg_ok;
        low_d = cfg_ok ? cfg_l : low_q;
        high_d = cfg_ok ? cfg_h : high_q;
      end
    end else if (live) begin
      pend_d = 1'b1;
      pclr_d = cfg_clr;
      plow_d = cfg_low;
      phigh_d = cfg_high;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      src_q <= 1'b0;
      hit_q <= 1'b0;
      prio_q <= 1'b0;
      cnt_q <= '0;
      en_q <= 1'b0;
      low_q <= '0;
      high_q <= '0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      pclr_q <= 1'b0;
      plow_q <= '0;
      phigh_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      src_q <= src_d;
      hit_q <= hit_d;
      prio_q <= prio_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      low_q <= low_d;
      high_q <= high_d;
      err_q <= err_d;
      pend_q <= pend_d;
      pclr_q <= pclr_d;
      plow_q <= plow_d;
      phigh_q <= phigh_d;
    end
  end
  assign busy = state_q != IDLE;
  assign iack = state_q == ACK && !src_q;
  assign dack = state_q == ACK && src_q;
  assign ihit = iack & hit_q;
  assign dhit = dack & hit_q;
  assign cl_req = state_q == CL_REQ;
  assign cl_addr = addr_q;
  assign cl_src = src_q;
  assign win_en = en_q;
  assign win_low = low_q;
  assign win_high = high_q;
  assign err = err_q;
endmodule

// File: tb/tb_smc_access_sched.sv
// tb_smc_access_sched: directed and randomized checks against a transaction-level window model
module tb_smc_access_sched;
  localparam int TMO = 4;
  logic clk = 0, rst = 0, cfg_we = 0, cfg_clr = 0, ireq = 0, dreq = 0, cl_done = 0;
  logic [31:0] cfg_low = 0, cfg_high = 0, iaddr = 0, daddr = 0;
  logic iack, ihit, dack, dhit, cl_req, cl_src, win_en, busy, err;
  logic [31:0] cl_addr, win_low, win_high;
  int vec = 0, miss = 0;
  bit m_en, m_err, m_prio, m_pend, m_pclr;
  logic [31:0] m_low, m_high, m_pl, m_ph;
  smc_access_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_low(cfg_low), .cfg_high(cfg_high),
    .ireq(ireq), .iaddr(iaddr), .iack(iack), .ihit(ihit), .dreq(dreq), .daddr(daddr), .dack(dack), .dhit(dhit),
    .cl_req(cl_req), .cl_addr(cl_addr), .cl_src(cl_src), .cl_done(cl_done), .win_en(win_en),
    .win_low(win_low), .win_high(win_high), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic mreset;
    m_en = 0; m_err = 0; m_prio = 0; m_pend = 0; m_pclr = 0;
    m_low = 0; m_high = 0; m_pl = 0; m_ph = 0;
  endtask
  task automatic mcfg(input bit we, input bit clr, input logic [31:0] lo, input logic [31:0] hi);
    if (clr) m_en = 0;
    else if (we && lo <= hi) begin
      m_en = 1; m_low = lo; m_high = hi; m_err = 0;
    end else if (we) begin
      m_en = 0; m_err = 1;
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {iack, ihit, dack, dhit, cl_req, cl_src, win_en, busy, err}, 0);
    chk({tag, "_cl_addr"}, cl_addr, 0);
    chk({tag, "_win_low"}, win_low, 0);
    chk({tag, "_win_high"}, win_high, 0);
  endtask
  task automatic cfg_idle(input bit we, input bit clr, input logic [31:0] lo, input logic [31:0] hi);
    if (m_pend) begin
      mcfg(1'b1, m_pclr, m_pl, m_ph);
      m_pend = 0;
      tick;
    end
    cfg_we = we; cfg_clr = clr; cfg_low = lo; cfg_high = hi;
    tick;
    cfg_we = 0; cfg_clr = 0;
    mcfg(we, clr, lo, hi);
    chk("cfg_win_en", win_en, m_en);
    chk("cfg_win_low", win_low, m_low);
    chk("cfg_win_high", win_high, m_high);
    chk("cfg_err", err, m_err);
    chk("cfg_busy", busy, 0);
  endtask
  task automatic xact(input bit ir, input bit dr, input logic [31:0] ia, input logic [31:0] da, input int d,
                      input bit pend, input bit pc, input logic [31:0] pl, input logic [31:0] ph, input bit noise);
    bit g, h, to;
    logic [31:0] a;
    int n;
    if (m_pend) begin
      mcfg(1'b1, m_pclr, m_pl, m_ph);
      m_pend = 0;
    end
    g = (ir && dr) ? m_prio : dr;
    m_prio = !g;
    a = g ? da : ia;
    h = m_en && (m_low <= a) && (a <= m_high);
    to = h && d >= TMO;
    ireq = ir; dreq = dr; iaddr = ia; daddr = da;
    tick;
    ireq = 0; dreq = 0; iaddr = $urandom; daddr = $urandom;
    chk("chk_busy", busy, 1);
    chk("chk_cl_req", cl_req, 0);
    chk("chk_ack", {iack, dack}, 0);
    chk("chk_win_en", win_en, m_en);
    cl_done = noise;
    tick;
    cl_done = 0;
    if (pend) begin
      cfg_we = !pc; cfg_clr = pc; cfg_low = pl; cfg_high = ph;
      m_pend = 1; m_pclr = pc; m_pl = pl; m_ph = ph;
    end
    if (h) begin
      n = to ? TMO : d + 1;
      for (int c = 0; c < n; c++) begin
        chk("clq_cl_req", cl_req, 1);
        chk("clq_cl_addr", cl_addr, a);
        chk("clq_cl_src", cl_src, g);
        chk("clq_win_en", win_en, m_en);
        chk("clq_err", err, m_err);
        chk("clq_ack", {iack, dack}, 0);
        cl_done = (c == d);
        tick;
        cl_done = 0; cfg_we = 0; cfg_clr = 0;
      end
      if (to) m_err = 1;
    end
    chk("ack_iack", iack, !g);
    chk("ack_dack", dack, g);
    chk("ack_ihit", ihit, !g && h && !to);
    chk("ack_dhit", dhit, g && h && !to);
    chk("ack_cl_req", cl_req, 0);
    chk("ack_err", err, m_err);
    chk("ack_busy", busy, 1);
    tick;
    cfg_we = 0; cfg_clr = 0;
    chk("post_busy", busy, 0);
    chk("post_ack_hit", {iack, dack, ihit, dhit}, 0);
    chk("post_win_en", win_en, m_en);
  endtask
  task automatic reset_mid(input logic [31:0] a);
    ireq = 1; iaddr = a;
    tick;
    ireq = 0;
    tick;
    chk("rm_cl_req_pre", cl_req, 1);
    rst = 0;
    tick;
    rst = 1;
    chk_reset("rm");
    mreset();
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("rm_noack", {iack, dack, busy}, 0);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return m_low;
      1: return m_high;
      2: return m_low - 32'd1;
      3: return m_high + 32'd1;
      default: return $urandom;
    endcase
  endfunction
  task automatic rnd_cfg(output bit clr, output logic [31:0] lo, output logic [31:0] hi);
    clr = $urandom_range(0, 5) == 0;
    lo = $urandom & 32'h000F_FFFF;
    hi = ($urandom_range(0, 4) == 0) ? lo - ($urandom & 32'hFF) - 32'd1 : lo + ($urandom & 32'hFFFF);
  endtask
  initial begin
    int n;
    mreset();
    repeat (3) tick;
    chk_reset("reset");
    rst = 1;
    tick;
    ireq = 1; dreq = 1; iaddr = 32'h40; daddr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(iack | dack) && n < 8) begin
        tick;
        n++;
      end
      chk("tie_in_time", n < 8, 1);
      chk("tie_iack", iack, k % 2 == 0);
      chk("tie_dack", dack, k % 2 == 1);
      m_prio = !m_prio;
      if (k == 3) begin
        ireq = 0; dreq = 0;
      end
      tick;
    end
    chk("tie_idle", busy, 0);
    cfg_idle(1, 0, 32'h1000, 32'h1FFF);
    xact(0, 1, 32'h0, 32'h1FFF, 3, 0, 0, 0, 0, 0);
    xact(1, 0, 32'h2000, 32'h0, 0, 0, 0, 0, 0, 0);
    xact(1, 0, 32'h0FFF, 32'h0, 0, 0, 0, 0, 0, 1);
    xact(1, 0, 32'h1000, 32'h0, 1, 1, 1, 0, 0, 1);
    xact(1, 0, 32'h1000, 32'h0, 0, 0, 0, 0, 0, 0);
    cfg_idle(1, 0, 32'h1000, 32'h1FFF);
    xact(0, 1, 32'h0, 32'h1800, 9, 0, 0, 0, 0, 0);
    cfg_idle(1, 0, 32'h1000, 32'h1FFF);
    cfg_idle(1, 0, 32'h3000, 32'h2000);
    cfg_idle(1, 1, 32'h0, 32'hFFFF);
    cfg_idle(1, 0, 32'h1000, 32'h1FFF);
    xact(1, 1, 32'h1001, 32'h1FFE, 0, 1, 0, 32'h5000, 32'h4000, 0);
    xact(1, 1, 32'h1001, 32'h1FFE, 0, 0, 0, 0, 0, 0);
    cfg_idle(1, 0, 32'h1000, 32'h1FFF);
    reset_mid(32'h1234);
    for (int i = 0; i < 80; i++) begin
      bit c;
      logic [31:0] l, h;
      int r;
      rnd_cfg(c, l, h);
      r = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) cfg_idle(1, c, l, h);
      else xact(r[0], r[1], pick(), pick(), $urandom_range(0, 5), $urandom_range(0, 2) == 0, c, l, h,
                $urandom_range(0, 1) == 1);
    end
    cfg_idle(1, 0, 32'h10, 32'h20);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/smc_access_sched.md
SMC_ACCESS_SCHED -- requirements
Module: smc_access_sched

Interface
REQ-001 Parameter: TIMEOUT, default 255, is the maximum number of cycles spent in CL_REQ before the transaction is aborted (range 1..255, 8-bit counter).
REQ-002 The module SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- cfg_we  in  1  window load strobe (l.start)
- cfg_clr  in  1  window disable strobe (l.end)
- cfg_low  in  32  window low bound, inclusive
- cfg_high  in  32  window high bound, inclusive
- ireq  in  1  instruction-side check request
- iaddr  in  32  instruction-side virtual address
- iack  out  1  instruction-side completion pulse
- ihit  out  1  instruction-side result, valid with iack
- dreq  in  1  data-side check request
- daddr  in  32  data-side virtual address
- dack  out  1  data-side completion pulse
- dhit  out  1  data-side result, valid with dack
- cl_req  out  1  cache-line encryption request
- cl_addr  out  32  address for the encryption engine
- cl_src  out  1  requester of the current encryption (0 = I, 1 = D)
- cl_done  in  1  encryption engine completion
- win_en  out  1  window valid
- win_low  out  32  active low bound
- win_high  out  32  active high bound
- busy  out  1  state is not IDLE
- err  out  1  sticky error (bad configuration or timeout)

Function
REQ-003 The FSM SHALL have the states IDLE, CHECK, CL_REQ and ACK, and busy SHALL equal (state != IDLE).
REQ-004 In IDLE, a sampled request SHALL be granted, and the address and requester SHALL be registered; the next state SHALL be CHECK.
REQ-005 When ireq and dreq are both high in IDLE, the grant SHALL go to the requester that was not granted last (round-robin); after reset, I SHALL win the first tie.
REQ-006 In CHECK, hit SHALL equal win_en AND (win_low <= addr) AND (addr <= win_high), using a 32-bit unsigned compare with both bounds inclusive.
REQ-007 From CHECK, a miss SHALL go to ACK and a hit SHALL go to CL_REQ.
REQ-008 In CL_REQ, cl_req SHALL be 1, and cl_addr and cl_src SHALL hold the registered values.
REQ-009 cl_done sampled high in CL_REQ SHALL cause a transition to ACK; cl_done outside CL_REQ SHALL be ignored.
REQ-010 The timeout counter SHALL be cleared on entry to CL_REQ and SHALL increment each cycle in CL_REQ without cl_done.
REQ-011 When the timeout counter reaches TIMEOUT, the FSM SHALL go to ACK with hit forced to 0 and SHALL set err.
REQ-012 In ACK, the granted requester's ack SHALL pulse for exactly one cycle, with its hit output valid in the same cycle; the next state SHALL be IDLE.
REQ-013 ihit and dhit SHALL be 0 whenever the corresponding ack is 0.
REQ-014 Latency SHALL be as follows:
- miss: ack 2 cycles after the request is sampled in IDLE;
- hit: ack 1 cycle after cl_done is sampled;
- minimum spacing between grants: 3 cycles.
REQ-015 Requesters SHALL hold req and addr stable until ack; a request dropped early SHALL still complete, and its ack SHALL still pulse.
REQ-016 cfg_we in IDLE SHALL apply next cycle:
- if cfg_low <= cfg_high: load the bounds and set win_en=1;
- otherwise: set win_en=0 and set err, with the bounds unchanged.
REQ-017 cfg_clr in IDLE SHALL set win_en=0 next cycle, with the bounds retained.
REQ-018 When cfg_we and cfg_clr are high in the same cycle, cfg_clr SHALL win.
REQ-019 A cfg strobe outside IDLE SHALL be held in a one-deep pending slot and applied in the first IDLE cycle.
REQ-020 A later pending strobe SHALL overwrite an earlier one.
REQ-021 A pending configuration SHALL be applied before any grant is made in that IDLE cycle, so the request granted in that cycle checks against the new window.
REQ-022 err SHALL clear only on reset or on a valid cfg_we (cfg_low <= cfg_high).

Reset
REQ-023 When rst is 0 at a clock edge, the block SHALL take the following values:
- state = IDLE;
- all outputs = 0 (iack, dack, ihit, dhit, cl_req, cl_addr, cl_src, win_en, win_low, win_high, busy, err);
- pending slot, round-robin pointer and timeout counter cleared.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction, drop cl_req at the next edge, and SHALL NOT issue an ack.

Verification
REQ-025 Window load: cfg_we with low=0x1000 and high=0x1FFF; dreq with daddr=0x1FFF -> cl_req=1, cl_addr=0x1FFF, cl_src=1; cl_done 3 cycles later -> dack=1 and dhit=1 one cycle after.
REQ-026 Miss and boundary: same window, iaddr=0x2000 and then iaddr=0x0FFF -> iack=1 and ihit=0 two cycles after each grant, with cl_req never asserted.
REQ-027 Tie arbitration: ireq and dreq held high for 4 transactions after reset -> grant order I, D, I, D.
REQ-028 Timeout: TIMEOUT=4, hit, cl_done held 0 -> cl_req high for 4 cycles, then dack=1, dhit=0 and err=1; a valid cfg_we afterwards -> err=0.
REQ-029 Deferred configuration: cfg_clr pulsed while in CL_REQ -> win_en stays 1 until the first IDLE cycle, and the next request at 0x1000 misses.
REQ-030 Bad configuration and reset: cfg_we with low=0x3000 and high=0x2000 -> win_en=0, err=1; reset during CL_REQ -> cl_req=0 at the next edge and no ack is issued.
